// File: rtl/i2c_slave_regs.sv
// i2c_slave_regs: I2C target with 8-bit auto-increment pointer into a byte register file; optional input glitch filter via I2C_SLV_GLITCH_FILTER_EN
module i2c_slave_regs #(
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         REG_DEPTH = 64
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       i2c_sclk,
    inout  wire        i2c_sdat,
    output logic       reg_wr_pulse,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    input  logic [7:0] host_addr,
    output logic [7:0] host_rdata,
    output logic       busy
);
    localparam int         AW     = REG_DEPTH > 1 ? $clog2(REG_DEPTH) : 1;
    localparam logic [8:0] DEPTH9 = 9'(REG_DEPTH);

    typedef enum logic [2:0] {IDLE, ADDR, ACK, PTR, WR, RD, RD_ACK, IGNORE} state_t;

    state_t     state, nxt;
    logic [1:0] scl_sync, sda_sync;
    logic       scl_cur, sda_cur, scl_prev, sda_prev;
    logic [3:0] bit_cnt;
    logic [6:0] sh;
    logic [7:0] ptr, tx;
    logic       sda_oe;
    logic [7:0] regs [REG_DEPTH];

    assign i2c_sdat = sda_oe ? 1'b0 : 1'bz;

    // two-flop synchronizers for both bus lines, idle-high after reset
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], i2c_sclk};
            sda_sync <= {sda_sync[0], i2c_sdat};
        end

`ifdef I2C_SLV_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;

    // sample history: a new level is taken only once three consecutive samples agree
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
        end

    assign scl_cur = (scl_hist == {2{scl_sync[1]}}) ? scl_sync[1] : scl_prev;
    assign sda_cur = (sda_hist == {2{sda_sync[1]}}) ? sda_sync[1] : sda_prev;
`else
    assign scl_cur = scl_sync[1];
    assign sda_cur = sda_sync[1];
`endif

    // previous accepted level for edge detection
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end

    wire       scl_rise = scl_cur & ~scl_prev;
    wire       scl_fall = ~scl_cur & scl_prev;
    wire       start    = sda_prev & ~sda_cur & scl_cur;
    wire       stop     = ~sda_prev & sda_cur & scl_cur;
    wire [7:0] byte_in  = {sh, sda_cur};
    wire [7:0] ptr_nx   = ptr + 8'd1;
    wire       ptr_in   = {1'b0, ptr} < DEPTH9;
    wire [7:0] rd_cur   = ptr_in ? regs[ptr[AW-1:0]] : 8'hFF;
    wire [7:0] rd_nx    = ({1'b0, ptr_nx} < DEPTH9) ? regs[ptr_nx[AW-1:0]] : 8'hFF;

    assign host_rdata = ({1'b0, host_addr} < DEPTH9) ? regs[host_addr[AW-1:0]] : 8'hFF;

    // bus protocol FSM; START/STOP override any SCL edge seen in the same cycle
    always_ff @(posedge Clk or posedge Rst)
        if (Rst) begin
            state        <= IDLE;
            nxt          <= IDLE;
            bit_cnt      <= '0;
            sh           <= '0;
            ptr          <= '0;
            tx           <= 8'hFF;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            reg_wr_pulse <= 1'b0;
            reg_wr_addr  <= '0;
            reg_wr_data  <= '0;
            for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
        end else begin
            reg_wr_pulse <= 1'b0;
            if (start) begin
                state   <= ADDR;
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
            end else if (stop) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else case (state)
                ADDR, PTR, WR:
                    if (scl_rise) begin
                        sh      <= byte_in[6:0];
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            bit_cnt <= '0;
                            state   <= ACK;
                            nxt     <= WR;
                            if (state == ADDR) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    busy <= 1'b1;
                                    nxt  <= byte_in[0] ? RD : PTR;
                                    tx   <= rd_cur;
                                end else begin
                                    state <= IGNORE;
                                end
                            end else if (state == PTR) begin
                                ptr <= byte_in;
                            end else begin
                                if (ptr_in) begin
                                    regs[ptr[AW-1:0]] <= byte_in;
                                    reg_wr_pulse      <= 1'b1;
                                    reg_wr_addr       <= ptr;
                                    reg_wr_data       <= byte_in;
                                end
                                ptr <= ptr_nx;
                            end
                        end
                    end
                ACK:
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            state   <= nxt;
                            bit_cnt <= '0;
                            sda_oe  <= (nxt == RD) ? ~tx[7] : 1'b0;
                            tx      <= (nxt == RD) ? {tx[6:0], 1'b1} : tx;
                        end
                    end
                RD: begin
                    if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                    if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe <= 1'b0;
                            state  <= RD_ACK;
                        end else begin
                            sda_oe <= ~tx[7];
                            tx     <= {tx[6:0], 1'b1};
                        end
                    end
                end
                RD_ACK:
                    if (scl_rise) begin
                        if (!sda_cur) begin
                            ptr     <= ptr_nx;
                            tx      <= rd_nx;
                            bit_cnt <= '0;
                            state   <= RD;
                        end else begin
                            state <= IGNORE;
                        end
                    end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb_i2c_slave_regs: bus-level initiator with scoreboard queues for write strobes and read bytes
module tb_i2c_slave_regs;
    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [7:0] host_addr = 8'h00;
    logic       reg_wr_pulse, busy;
    logic [7:0] reg_wr_addr, reg_wr_data, host_rdata;
    wire        sda_bus;

    pullup (sda_bus);
    assign sda_bus = sda_low ? 1'b0 : 1'bz;

    i2c_slave_regs dut (
        .Clk(Clk), .Rst(Rst), .i2c_sclk(scl), .i2c_sdat(sda_bus),
        .reg_wr_pulse(reg_wr_pulse), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .host_addr(host_addr), .host_rdata(host_rdata), .busy(busy)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic        low_seen = 1'b0;
    logic        busy_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // every strobe must match the next queued {addr,data}
    always @(negedge Clk) begin
        if (!Rst && reg_wr_pulse) begin
            if (wr_q.size() == 0) chk("unexpected_pulse", {16'h0, reg_wr_addr, reg_wr_data}, 32'hFFFF_FFFF);
            else chk("wr_pulse", {16'h0, reg_wr_addr, reg_wr_data}, {16'h0, wr_q.pop_front()});
        end
        if (!sda_low && sda_bus === 1'b0) low_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
    end

    task automatic q(input int n = 10);
        repeat (n) @(negedge Clk);
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; q();
        scl = 1'b1; q();
        sda_low = 1'b1; q();
        scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; q();
        scl = 1'b1; q();
        sda_low = 1'b0; q();
    endtask

    task automatic bit_out(input logic b, input logic glitch);
        sda_low = ~b;
        if (glitch) begin
            q(5); scl = 1'b1; q(1); scl = 1'b0; q(4);
        end else q();
        scl = 1'b1; q();
        scl = 1'b0; q();
    endtask

    task automatic bit_in(output logic b);
        sda_low = 1'b0; q();
        scl = 1'b1; q(5);
        b = sda_bus; q(5);
        scl = 1'b0; q();
    endtask

    task automatic send(input logic [7:0] v, input logic exp_ack, input string tag, input int gl);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(v[i], i == gl);
        bit_in(a);
        chk(tag, {31'h0, a}, {31'h0, exp_ack});
    endtask

    task automatic recv(input logic ack_bit, input string tag);
        logic [7:0] v;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            bit_in(b);
            v[i] = b;
        end
        bit_out(ack_bit, 1'b0);
        if (rd_q.size() == 0) chk("unexpected_read", {24'h0, v}, 32'hFFFF_FFFF);
        else chk(tag, {24'h0, v}, {24'h0, rd_q.pop_front()});
    endtask

    task automatic hread(input logic [7:0] a, input logic [7:0] exp, input string tag);
        host_addr = a;
        #1;
        chk(tag, {24'h0, host_rdata}, {24'h0, exp});
    endtask

    initial begin
        logic       b;
        logic [7:0] glitch_exp;
        logic       glitch_ack;
        q(3);
        Rst = 1'b0;
        q(3);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_pulse", {31'h0, reg_wr_pulse}, 0);
        chk("rst_wr_addr", {24'h0, reg_wr_addr}, 0);
        chk("rst_wr_data", {24'h0, reg_wr_data}, 0);
        chk("rst_sda", {31'h0, sda_bus}, 1);
        hread(8'h00, 8'h00, "rst_reg0");
        hread(8'h3F, 8'h00, "rst_reg3f");
        hread(8'h40, 8'hFF, "oob_40");
        hread(8'hFF, 8'hFF, "oob_ff");

        // single write
        wr_q.push_back({8'h05, 8'hA5});
        i2c_start();
        send(8'h34, 1'b0, "t1_addr_ack", -1);
        chk("t1_busy_hi", {31'h0, busy}, 1);
        send(8'h05, 1'b0, "t1_ptr_ack", -1);
        send(8'hA5, 1'b0, "t1_data_ack", -1);
        i2c_stop();
        chk("t1_busy_lo", {31'h0, busy}, 0);
        hread(8'h05, 8'hA5, "t1_host");

        // write running off the end of the register file
        wr_q.push_back({8'h3F, 8'h11});
        i2c_start();
        send(8'h34, 1'b0, "t2_addr_ack", -1);
        send(8'h3F, 1'b0, "t2_ptr_ack", -1);
        send(8'h11, 1'b0, "t2_d0_ack", -1);
        send(8'h22, 1'b0, "t2_d1_ack", -1);
        send(8'h33, 1'b0, "t2_d2_ack", -1);
        i2c_stop();
        hread(8'h3F, 8'h11, "t2_host3f");
        hread(8'h3E, 8'h00, "t2_host3e");
        rd_q.push_back(8'hFF);
        i2c_start();
        send(8'h35, 1'b0, "t2_rd_addr_ack", -1);
        recv(1'b1, "t2_rd_oob");
        i2c_stop();

        // preload then pointer write, repeated START, sequential read
        wr_q.push_back({8'h10, 8'h5A});
        wr_q.push_back({8'h11, 8'hC3});
        i2c_start();
        send(8'h34, 1'b0, "t3_pre_addr", -1);
        send(8'h10, 1'b0, "t3_pre_ptr", -1);
        send(8'h5A, 1'b0, "t3_pre_d0", -1);
        send(8'hC3, 1'b0, "t3_pre_d1", -1);
        i2c_stop();
        i2c_start();
        send(8'h34, 1'b0, "t3_addr_w", -1);
        send(8'h10, 1'b0, "t3_ptr", -1);
        i2c_start();
        send(8'h35, 1'b0, "t3_addr_r", -1);
        rd_q.push_back(8'h5A);
        rd_q.push_back(8'hC3);
        recv(1'b0, "t3_rd0");
        recv(1'b1, "t3_rd1");
        low_seen = 1'b0;
        q(20);
        chk("t3_released", {31'h0, low_seen}, 0);
        i2c_stop();

        // foreign address is ignored entirely
        busy_seen = 1'b0;
        low_seen = 1'b0;
        i2c_start();
        send(8'h36, 1'b1, "t4_addr_nack", -1);
        send(8'h55, 1'b1, "t4_d0_nack", -1);
        send(8'hAA, 1'b1, "t4_d1_nack", -1);
        i2c_stop();
        chk("t4_no_drive", {31'h0, low_seen}, 0);
        chk("t4_no_busy", {31'h0, busy_seen}, 0);

        // pointer preserved at 0x11 (0xC3); reset during the 4th bit, which is driven low
        i2c_start();
        send(8'h35, 1'b0, "t5_addr", -1);
        bit_in(b); chk("t5_bit7", {31'h0, b}, 1);
        bit_in(b); chk("t5_bit6", {31'h0, b}, 1);
        bit_in(b); chk("t5_bit5", {31'h0, b}, 0);
        sda_low = 1'b0; q();
        scl = 1'b1; q(5);
        chk("t5_bit4_driven", {31'h0, sda_bus}, 0);
        #2 Rst = 1'b1;
        #1 chk("t5_async_release", {31'h0, sda_bus}, 1);
        q(2);
        Rst = 1'b0;
        scl = 1'b0; q();
        i2c_stop();
        chk("t5_busy", {31'h0, busy}, 0);
        chk("t5_wr_addr", {24'h0, reg_wr_addr}, 0);
        chk("t5_wr_data", {24'h0, reg_wr_data}, 0);
        hread(8'h10, 8'h00, "t5_reg10_clr");
        hread(8'h05, 8'h00, "t5_reg05_clr");
        wr_q.push_back({8'h07, 8'h99});
        i2c_start();
        send(8'h34, 1'b0, "t5_w_addr", -1);
        send(8'h07, 1'b0, "t5_w_ptr", -1);
        send(8'h99, 1'b0, "t5_w_data", -1);
        i2c_stop();
        hread(8'h07, 8'h99, "t5_host07");

        // one-Clk SCL glitch before bit 3 of a data byte
`ifdef I2C_SLV_GLITCH_FILTER_EN
        glitch_exp = 8'hB6;
        glitch_ack = 1'b0;
`else
        glitch_exp = 8'hB3;
        glitch_ack = 1'b1;
`endif
        wr_q.push_back({8'h20, glitch_exp});
        i2c_start();
        send(8'h34, 1'b0, "t6_addr", -1);
        send(8'h20, 1'b0, "t6_ptr", -1);
        send(8'hB6, glitch_ack, "t6_data_ack", 3);
        i2c_stop();
        hread(8'h20, glitch_exp, "t6_host20");

        q(5);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (slave) that answers an external I2C initiator on the board's SCL/SDA pair and exposes a byte-wide register file to the FPGA fabric. It accepts 7-bit-addressed write and read transactions with an 8-bit register pointer and auto-increment. Each write is reported to the fabric as a one-cycle strobe, and the fabric can read any register asynchronously. It is the responder counterpart of the team's I2C init master, and serves as a loop-back target for that master's bench and as a host-visible control port.

## Interface
- DEV_ADDR, 7'h1A: 7-bit target address; the R/W bit is excluded.
- REG_DEPTH, 64: number of implemented byte registers, range 1..256.
- Clk  input  1  system clock; must be at least 20× the SCL frequency.
- Rst  input  1  reset; one clock, reset is asynchronous and active-high.
- i2c_sclk  input  1  I2C clock from the initiator; clock stretching is not supported.
- i2c_sdat  inout  1  I2C data; the block drives only 0 or Z, with external pull-up.
- reg_wr_pulse  output  1  one-cycle strobe for an I2C write into an implemented register.
- reg_wr_addr  output  8  register index of the last write.
- reg_wr_data  output  8  data of the last write.
- host_addr  input  8  fabric read index.
- host_rdata  output  8  combinational read of reg[host_addr]; returns 8'hFF if host_addr ≥ REG_DEPTH.
- busy  output  1  high from a START that addresses this block until the following STOP.

## Operation
- Input path: i2c_sclk and i2c_sdat each pass through a 2-FF synchronizer, followed by previous-sample edge detection.
- Bus conditions:
  - START / repeated START: SDA falls while SCL is high. From any state, go to ADDR, clear the bit counter, release SDA.
  - STOP: SDA rises while SCL is high. From any state, go to IDLE, release SDA, busy=0.
- Data is sampled on the SCL rising edge. The block changes SDA only after an SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits, MSB first. If bits[7:1]==DEV_ADDR, go to ADDR_ACK, set busy=1, and latch the R/W bit. Otherwise go to IGNORE; no ACK is driven.
  - ADDR_ACK: drive SDA low from the falling edge after bit 8 to the falling edge after bit 9.
    - R/W=0: go to PTR.
    - R/W=1: load the TX shift register from reg[ptr] (8'hFF if ptr ≥ REG_DEPTH) and go to RD.
  - PTR: shift in 8 bits, ptr ← byte, ACK, go to WR.
  - WR: shift in 8 bits, then ACK.
    - If ptr < REG_DEPTH: reg[ptr] ← byte and pulse reg_wr_pulse. Otherwise discard the byte, but still ACK.
    - Then ptr ← ptr+1, go to WR.
  - RD: on each falling edge, output TX[7], MSB first; SDA=0 drives low, SDA=1 releases. After 8 bits, release SDA and go to RD_ACK.
  - RD_ACK: sample the initiator's bit on the 9th rising edge.
    - ACK (0): ptr ← ptr+1, reload TX, go to RD.
    - NACK (1): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- Pointer rules:
  - ptr is 8 bits, wraps 8'hFF→8'h00, and is preserved across transactions. This allows a pointer write, repeated START, then sequential read.
  - Reset sets ptr=0.
- Register file: REG_DEPTH×8 flops, all reset to 8'h00. host_rdata is independent of I2C activity. A same-cycle write and host read returns the old value.

## Timing
- Reset values: all registers 8'h00, ptr=0, state=IDLE, SDA released, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0, busy=0.
- Reset asserted mid-transfer releases SDA asynchronously, with no wait for a clock edge.
- Input latency: 2 Clk cycles from pin to detected edge, or 4 cycles with the filter (see Configuration).
- The SDA drive change occurs 1 Clk after the detected SCL falling edge.
- reg_wr_pulse rises 1 Clk after the 8th data-bit rising edge is detected and lasts exactly 1 Clk. reg_wr_addr, reg_wr_data and reg[ptr] update on that same edge.
- busy rises in the cycle after the address match and falls in the cycle after STOP is detected.
- A START or STOP detected in the same cycle as an SCL edge takes priority; the SCL edge is ignored.

## Configuration
- I2C_SLV_GLITCH_FILTER_EN:
  - Defined: each synchronized line passes through an additional 2-cycle stable-value filter. A level change is accepted only after 3 consecutive equal samples, so pulses of 2 Clk or less are rejected. Input latency becomes 4 Clk.
  - Undefined: no filter; latency is 2 Clk and every synchronized transition is honoured.

## Test plan
- Write 0x34 (addr 0x1A+W), 0x05, 0xA5, STOP → three ACKs; one reg_wr_pulse with addr 0x05 / data 0xA5; host_addr=0x05 gives host_rdata=0xA5; busy drops after STOP.
- REG_DEPTH=64: write 0x34, 0x3F, 0x11, 0x22, 0x33 → all ACKed; reg[0x3F]=0x11; exactly one pulse; ptr=0x42 afterwards.
- Random read: preload reg[0x10]=0x5A, reg[0x11]=0xC3. Send 0x34, 0x10, repeated START, 0x35, read 2 bytes (ACK then NACK) → SDA returns 0x5A then 0xC3; the block then releases SDA until STOP.
- Wrong address 0x36 followed by data bytes → SDA never driven low, no pulse, busy stays 0.
- Assert Rst during the 4th bit of a read byte → SDA released before the next Clk edge; state IDLE; ptr=0; the next valid write succeeds.
- With I2C_SLV_GLITCH_FILTER_EN: inject a 1-Clk SCL high pulse mid-byte → bit count unchanged; received byte correct. Without the macro, the same stimulus corrupts the byte.
